// File: rtl/tt_mux_seq.sv
// Sequenced row mux: routes the spine to one user module, with a guard interval on every selection change.
// Optional macro TT_MUX_OW_PIPE_EN registers spine_ow (one extra clock of latency).
module tt_mux_seq #(
  parameter int N_UM      = 16,
  parameter int N_IO      = 8,
  parameter int N_O       = 8,
  parameter int N_I       = 10,
  parameter int GUARD_CYC = 4,
  parameter int U_OW      = N_O + 2 * N_IO,
  parameter int U_IW      = N_I + N_IO
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [U_OW*N_UM-1:0]   um_ow,
  output logic [U_IW*N_UM-1:0]   um_iw,
  output logic [N_UM-1:0]        um_ena,
  output logic [U_OW-1:0]        spine_ow,
  input  logic [U_IW-1:0]        spine_iw,
  input  logic [9:0]             spine_sel,
  input  logic                   spine_ena,
  input  logic [4:0]             addr,
  output logic                   busy
);

  typedef enum logic [1:0] {S_OFF, S_GUARD, S_ON} state_t;

  localparam logic [3:0] GLOAD = 4'(GUARD_CYC - 1);
  localparam logic [5:0] NUM6  = 6'(N_UM);

  state_t          state_q, state_d;
  logic [4:0]      col_q, col_d;
  logic [3:0]      gcnt_q, gcnt_d;
  logic [N_UM-1:0] ena_q, ena_d;
  logic            busy_q;
  logic            req_vld;
  logic [4:0]      tcol;
  logic [U_OW-1:0] ow_src;

  assign tcol    = spine_sel[4:0];
  assign req_vld = spine_ena && (spine_sel[9:5] == addr) && ({1'b0, tcol} < NUM6);

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    gcnt_d  = gcnt_q;
    case (state_q)
      S_OFF: begin
        if (req_vld) begin
          state_d = S_GUARD;
          col_d   = tcol;
          gcnt_d  = GLOAD;
        end
      end
      S_GUARD: begin
        if (!req_vld) begin
          state_d = S_OFF;
        end else if (tcol != col_q) begin
          col_d  = tcol;
          gcnt_d = GLOAD;
        end else if (gcnt_q == 4'd0) begin
          state_d = S_ON;
        end else begin
          gcnt_d = gcnt_q - 4'd1;
        end
      end
      S_ON: begin
        if (!req_vld) begin
          state_d = S_OFF;
        end else if (tcol != col_q) begin
          state_d = S_GUARD;
          col_d   = tcol;
          gcnt_d  = GLOAD;
        end
      end
      default: state_d = S_OFF;
    endcase
  end

  // Enable is decoded from the next state so it is a clean register output.
  always_comb begin
    ena_d = '0;
    for (int k = 0; k < N_UM; k++) begin
      ena_d[k] = (state_d == S_ON) && (col_d == 5'(k));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_OFF;
      col_q   <= 5'd0;
      gcnt_q  <= 4'd0;
      ena_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      gcnt_q  <= gcnt_d;
      ena_q   <= ena_d;
      busy_q  <= (state_d == S_GUARD);
    end
  end

  assign um_ena = ena_q;
  assign busy   = busy_q;

  for (genvar k = 0; k < N_UM; k++) begin : g_iw
    assign um_iw[U_IW*k +: U_IW] = ena_q[k] ? spine_iw : '0;
  end

  always_comb begin
    ow_src = '0;
    if (state_q == S_ON) begin
      for (int k = 0; k < N_UM; k++) begin
        if (col_q == 5'(k)) ow_src = um_ow[U_OW*k +: U_OW];
      end
    end
  end

`ifdef TT_MUX_OW_PIPE_EN
  logic [U_OW-1:0] ow_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ow_q <= '0;
    else        ow_q <= ow_src;
  end

  assign spine_ow = ow_q;
`else
  assign spine_ow = ow_src;
`endif

endmodule

// File: tb/tb_tt_mux_seq.sv
// Bench for tt_mux_seq: run-length reference model, per-cycle compare, directed literal checks, random phase.
module tb_tt_mux_seq;
  localparam int N_UM = 16;
  localparam int N_IO = 8;
  localparam int N_O  = 8;
  localparam int N_I  = 10;
  localparam int G    = 4;
  localparam int U_OW = N_O + 2 * N_IO;
  localparam int U_IW = N_I + N_IO;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [U_OW*N_UM-1:0] um_ow = '0;
  logic [U_IW*N_UM-1:0] um_iw;
  logic [N_UM-1:0]      um_ena;
  logic [U_OW-1:0]      spine_ow;
  logic [U_IW-1:0]      spine_iw = '0;
  logic [9:0]           spine_sel = '0;
  logic                 spine_ena = 1'b0;
  logic [4:0]           addr = 5'd5;
  logic                 busy;

  int n_chk = 0;
  int n_pass = 0;

  tt_mux_seq #(.N_UM(N_UM), .N_IO(N_IO), .N_O(N_O), .N_I(N_I), .GUARD_CYC(G)) dut (
    .clk(clk), .rst_n(rst_n), .um_ow(um_ow), .um_iw(um_iw), .um_ena(um_ena),
    .spine_ow(spine_ow), .spine_iw(spine_iw), .spine_sel(spine_sel),
    .spine_ena(spine_ena), .addr(addr), .busy(busy)
  );

  always #5 clk = ~clk;

  // Model: a module is enabled once the same valid column has been requested
  // on G+1 consecutive edges; edges 1..G of such a run are the guard.
  int              run = 0;
  int              mcol = 0;
  logic [U_OW-1:0] mpipe = '0;

  always @(posedge clk or negedge rst_n) begin
    logic            vld;
    int              tc;
    if (!rst_n) begin
      run   = 0;
      mcol  = 0;
      mpipe = '0;
    end else begin
      tc  = int'(spine_sel[4:0]);
      vld = spine_ena && (spine_sel[9:5] == addr) && (tc < N_UM);
      mpipe = (run >= G + 1) ? um_ow[U_OW*mcol +: U_OW] : '0;
      if (!vld) run = 0;
      else if (run > 0 && tc == mcol) run = (run >= G + 1) ? G + 1 : run + 1;
      else begin
        run  = 1;
        mcol = tc;
      end
    end
  end

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  always @(negedge clk) begin
    logic [N_UM-1:0]      e_ena;
    logic [U_IW*N_UM-1:0] e_iw;
    logic [U_OW-1:0]      e_ow;
    logic                 e_busy;
    e_ena  = '0;
    e_iw   = '0;
    e_ow   = '0;
    e_busy = (run >= 1) && (run <= G);
    if (run >= G + 1) begin
      e_ena[mcol] = 1'b1;
      e_iw[U_IW*mcol +: U_IW] = spine_iw;
      e_ow = um_ow[U_OW*mcol +: U_OW];
    end
`ifdef TT_MUX_OW_PIPE_EN
    e_ow = mpipe;
`endif
    chk("cyc_ena", 512'(um_ena), 512'(e_ena));
    chk("cyc_busy", 512'(busy), 512'(e_busy));
    chk("cyc_iw", 512'(um_iw), 512'(e_iw));
    chk("cyc_ow", 512'(spine_ow), 512'(e_ow));
  end

  task automatic rnd_data();
    for (int i = 0; i < U_OW * N_UM; i++) um_ow[i] = 1'($urandom_range(0, 1));
    spine_iw = U_IW'($urandom);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    rnd_data();
    #1;
  endtask

  task automatic req(input logic en, input logic [4:0] row, input logic [4:0] col);
    spine_ena = en;
    spine_sel = {row, col};
  endtask

  initial begin
    logic [4:0] rcol;
    rnd_data();
    spine_sel = 10'(($urandom));
    spine_ena = 1'b1;
    repeat (3) tick();
    chk("rst_ena", 512'(um_ena), 512'(0));
    chk("rst_ow", 512'(spine_ow), 512'(0));
    chk("rst_iw", 512'(um_iw), 512'(0));
    chk("rst_busy", 512'(busy), 512'(0));
    req(0, 5, 3);
    #3 rst_n = 1'b1;
    repeat (3) tick();
    chk("off_ena", 512'(um_ena), 512'(0));
    chk("off_busy", 512'(busy), 512'(0));

    req(1, 5, 3);
    tick();
    chk("sel_busy_e1", 512'(busy), 512'(1));
    chk("sel_ena_e1", 512'(um_ena), 512'(0));
    repeat (3) tick();
    chk("sel_ena_e4", 512'(um_ena), 512'(0));
    tick();
    chk("sel_ena_e5", 512'(um_ena), 512'(16'h0008));
    chk("sel_busy_e5", 512'(busy), 512'(0));
    chk("sel_iw3", 512'(um_iw[U_IW*3 +: U_IW]), 512'(spine_iw));
    chk("sel_iw_others", 512'(um_iw & ~({{(U_IW*N_UM-U_IW){1'b0}}, {U_IW{1'b1}}} << (U_IW*3))), 512'(0));
`ifndef TT_MUX_OW_PIPE_EN
    chk("sel_ow", 512'(spine_ow), 512'(um_ow[U_OW*3 +: U_OW]));
`endif

    req(1, 5, 7);
    tick();
    chk("rt_ena_e1", 512'(um_ena), 512'(0));
    chk("rt_busy_e1", 512'(busy), 512'(1));
    repeat (3) tick();
    chk("rt_ena_e4", 512'(um_ena), 512'(0));
    tick();
    chk("rt_ena_e5", 512'(um_ena), 512'(16'h0080));

    req(1, 5, 9);
    repeat (2) tick();
    req(1, 5, 10);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("gr_ena_wait", 512'(um_ena), 512'(0));
    end
    tick();
    chk("gr_ena_col10", 512'(um_ena), 512'(16'h0400));

    req(1, 6, 10);
    tick();
    chk("row_ena", 512'(um_ena), 512'(0));
    chk("row_busy", 512'(busy), 512'(0));
    chk("row_ow", 512'(spine_ow), 512'(0));
    req(1, 5, 2);
    repeat (5) tick();
    chk("c2_ena", 512'(um_ena), 512'(16'h0004));
    req(1, 5, 20);
    tick();
    chk("col20_ena", 512'(um_ena), 512'(0));
    chk("col20_busy", 512'(busy), 512'(0));
    req(1, 5, 1);
    repeat (2) tick();
    chk("dg_busy_on", 512'(busy), 512'(1));
    req(0, 5, 1);
    tick();
    chk("dg_busy_off", 512'(busy), 512'(0));
    chk("dg_ena", 512'(um_ena), 512'(0));

    rcol = 5'd0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        rcol = 5'($urandom_range(0, 19));
        case ($urandom_range(0, 9))
          0:       req(0, 5, rcol);
          1:       req(1, 5'($urandom_range(0, 31)), rcol);
          default: req(1, 5, rcol);
        endcase
      end
      tick();
    end

    req(1, 5, 4);
    repeat (6) tick();
    chk("ar_ena_on", 512'(um_ena), 512'(16'h0010));
    #1 rst_n = 1'b0;
    #1;
    chk("ar_ena", 512'(um_ena), 512'(0));
    chk("ar_ow", 512'(spine_ow), 512'(0));
    chk("ar_iw", 512'(um_iw), 512'(0));
    chk("ar_busy", 512'(busy), 512'(0));
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (8) tick();
    chk("post_ar_ena", 512'(um_ena), 512'(16'h0010));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
